nes_controller_port: RTL
========================

Name: nes_controller_port

Overview:
- CPU-side responder for the two NES joypad registers, $4016 and $4017, selected by the CPU address decoder through controller_cs_n and controller_addr.
- Turns parallel button state (from the MicroBlaze/USB keyboard path) into the serial, strobe-latched read protocol the 6502 software expects.
- Sits on clk_ctrl, which is the CPU clock, alongside the PPU and APU register responders on the shared CPU data bus.

Parameters:
- OPEN_BUS, 8'h40: value driven on data_out[7:1] during reads.
- SYNC_STAGES, 2: flop stages on button inputs. Legal range is 1..3.
- BLOCK_OPPOSING, 1: when 1, the latch masks Up+Down and Left+Right pressed together to "neither pressed".

Ports:
- clk  in  1  CPU clock (clk_ctrl).
- reset  in  1  synchronous, active-high reset.
- cs_n  in  1  active-low chip select from the address decoder.
- addr  in  1  0 = $4016, 1 = $4017.
- rw  in  1  1 = read, 0 = write (same sense as rw_ctrl).
- data_in  in  8  CPU write data.
- data_out  out  8  read data.
- data_oe  out  1  high while this block drives the CPU data bus.
- buttons_p1  in  8  player 1 button state, asynchronous, active-high. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- buttons_p2  in  8  player 2 button state, same bit order.
- strobe  out  1  current latch-strobe state (debug and HEX display).
- read_count_p1  out  4  reads of $4016 since the last latch, saturating at 15.

Behaviour:
- Reset (synchronous, active-high):
  - strobe=0.
  - Both shift registers = 8'h00.
  - Synchronizer flops = 0.
  - read_count_p1 = 0.
  - cs_n edge-detect register = 1.
  - Reset asserted mid-access cancels any pending shift. After reset deasserts, reads return OPEN_BUS|0 until the next latch.
- Access start:
  - access_start = !cs_n && cs_prev_n, where cs_prev_n is cs_n registered.
  - Each access produces exactly one side effect, no matter how many cycles cs_n stays low.
- Write to addr 0 (access_start, rw=0, addr=0): strobe <= data_in[0] at the end of that cycle.
- Write to addr 1: ignored, since it belongs to the APU frame counter. data_oe stays 0.
- Latching:
  - While strobe=1, both shift registers reload every cycle from the synchronized, masked buttons. read_count_p1 is held at 0.
  - On the strobe 1->0 transition, the final reload happens in that same cycle.
- Read, combinational during the access (!cs_n && rw=1):
  - data_oe=1.
  - data_out = {OPEN_BUS[7:1], sr_sel[0]}, where sr_sel is the shift register chosen by addr.
  - If strobe=1, bit0 = live synchronized A button.
  - No register latency: data is valid in the first cycle of the access.
- Shift:
  - On access_start with rw=1 and strobe=0, the selected register shifts right by one and fills 1 at bit 7.
  - read_count_p1 increments only on $4016 reads, saturating at 15.
  - Reads 1..8 return A,B,Select,Start,Up,Down,Left,Right.
  - Read 9 onward returns 1.
  - The two registers shift independently.
- Read with strobe=1: returns A, no shift.
- BLOCK_OPPOSING masking is applied on the synchronized buttons before latching: bits {5,4}==2'b11 become 2'b00, and bits {7,6}==2'b11 become 2'b00.
- Outside reads: data_out=8'h00 and data_oe=0.

Decomposition:
- Shared package (alongside Games): button bit-index localparams (BTN_A..BTN_RIGHT), the CTRL_ADDR_P1/CTRL_ADDR_P2 constants, and a typedef for the 8-bit button vector.
- Sub-module ctrl_shift_reg, instantiated once per player. It contains the synchronizer, the opposing-direction mask, the 8-bit register, and the load/shift/fill-1 logic. Its inputs are load, shift and buttons; its output is bit0.
- The top handles decode, cs edge detection, strobe and the counter.

Test Plan:
- Latch and read P1:
  - Stimulus: buttons_p1=8'b1000_1001; write $4016=1, then $4016=0; then 10 single-cycle reads of $4016.
  - Required bit0 sequence: 1,0,0,1,0,0,0,1,1,1.
  - data_out[7:1] = 7'h20 on every read.
  - read_count_p1 reaches 10.
- Long access:
  - Stimulus: cs_n held low for 4 cycles on a read, then two further single reads.
  - Required: only one shift happens; the next reads return bits 1 and 2.
- Strobe held high:
  - Stimulus: strobe=1, A toggled between reads, 3 reads.
  - Required: each read returns live A; no shift; read_count_p1=0.
- Independent players:
  - Stimulus: buttons_p2=8'h02; latch; read $4017 twice, then $4016 once.
  - Required: P2 returns 0 then 1; P1 returns its own bit0 and is unaffected by the P2 reads.
- Opposing mask and sync latency:
  - Stimulus: BLOCK_OPPOSING=1, Up+Down+A pressed, buttons changed 1 cycle before the latch.
  - Required: latch captures the old value (SYNC_STAGES=2). After waiting, it captures bits 4,5 = 0 and A=1.
- Reset mid-sequence:
  - Stimulus: reset after 3 reads.
  - Required: strobe=0, read_count_p1=0, next read data_out=8'h40; writes to $4017 leave data_oe=0.

Source files
------------

// File: rtl/nes_controller_port_pkg.sv
// Shared joypad definitions: button bit positions, register addresses and the
// opposing-direction mask used when latching.
package nes_controller_port_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic CTRL_ADDR_P1 = 1'b0;  // $4016
  localparam logic CTRL_ADDR_P2 = 1'b1;  // $4017

  localparam int NUM_PLAYERS = 2;

  typedef logic [7:0] buttons_t;

  // Physically impossible pad states (Up+Down, Left+Right) read as neither.
  function automatic buttons_t mask_opposing(input buttons_t b);
    buttons_t m;
    m = b;
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      m[BTN_UP]   = 1'b0;
      m[BTN_DOWN] = 1'b0;
    end
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      m[BTN_LEFT]  = 1'b0;
      m[BTN_RIGHT] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/ctrl_shift_reg.sv
// One joypad: input synchronizer, opposing-direction mask and the 8-bit
// parallel-load / serial-out register that fills with 1s as it drains.
module ctrl_shift_reg
  import nes_controller_port_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter bit BLOCK_OPPOSING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] buttons,
  output logic       bit0
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  buttons_t synced, masked, sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= buttons;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign masked = BLOCK_OPPOSING ? mask_opposing(synced) : synced;

  always_ff @(posedge clk) begin
    if (reset)      sr <= '0;
    else if (load)  sr <= masked;
    else if (shift) sr <= {1'b1, sr[7:1]};
  end

  // While strobing, software sees the live A button rather than the stale copy.
  assign bit0 = load ? masked[BTN_A] : sr[0];

endmodule

// File: rtl/nes_controller_port.sv
// $4016/$4017 responder: decodes CPU accesses, owns the latch strobe and the
// P1 read counter, and serializes both pads onto data_out[0].
module nes_controller_port
  import nes_controller_port_pkg::*;
#(
  parameter logic [7:0] OPEN_BUS       = 8'h40,
  parameter int         SYNC_STAGES    = 2,
  parameter bit         BLOCK_OPPOSING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] buttons_p1,
  input  logic [7:0] buttons_p2,
  output logic       strobe,
  output logic [3:0] read_count_p1
);

  logic cs_prev_n, access_start, rd_active, rd_start, wr_strobe;
  logic [NUM_PLAYERS-1:0]      shift, bit0;
  logic [NUM_PLAYERS-1:0][7:0] btns;
  logic                        unused_data_in;

  assign unused_data_in = ^data_in[7:1];

  // One side effect per access regardless of how long cs_n stays low.
  assign access_start = !cs_n && cs_prev_n;
  assign rd_active    = !cs_n && rw;
  assign rd_start     = access_start && rw;
  assign wr_strobe    = access_start && !rw && (addr == CTRL_ADDR_P1);
  assign btns         = {buttons_p2, buttons_p1};

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_prev_n <= 1'b1;
      strobe    <= 1'b0;
    end else begin
      cs_prev_n <= cs_n;
      if (wr_strobe) strobe <= data_in[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || strobe)
      read_count_p1 <= '0;
    else if (rd_start && addr == CTRL_ADDR_P1 && read_count_p1 != 4'hF)
      read_count_p1 <= read_count_p1 + 4'd1;
  end

  // strobe is still 1 in the cycle it is cleared, giving the final reload.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pad
    assign shift[p] = rd_start && !strobe && (addr == 1'(p));

    ctrl_shift_reg #(
      .SYNC_STAGES    (SYNC_STAGES),
      .BLOCK_OPPOSING (BLOCK_OPPOSING)
    ) u_sr (
      .clk     (clk),
      .reset   (reset),
      .load    (strobe),
      .shift   (shift[p]),
      .buttons (btns[p]),
      .bit0    (bit0[p])
    );
  end

  assign data_oe  = rd_active;
  assign data_out = rd_active ? {OPEN_BUS[7:1], bit0[addr]} : 8'h00;

endmodule
